// File: rtl/spi_slave.sv
// spi_slave: SPI responder for the 8-bit, MSB-first link from our SPI master.
// SCK idles high; MOSI is captured on SCK rise and MISO is updated on SCK fall.
// All pins are oversampled on clk_in. Bursts are supported while CS stays low.
// Optional macro SPI_SLAVE_ABORT_FLAG_EN adds the abort / abort_bits outputs,
// which report a CS rise that cut a word short.
module spi_slave #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        MISO_IDLE   = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    output logic                  abort,
    output logic [3:0]            abort_bits,
`endif
    output logic                  busy
);

    localparam int unsigned    IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sck_hist;
    logic                   cs_hist;
    logic                   sck_sync;
    logic                   cs_sync;
    logic                   mosi_sync;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  tx_shift;
    // Only the low W-1 received bits need storing; the last bit arrives
    // live from mosi_sync when the word completes.
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_word;

    // Synchronizer chains plus one history flop for SCK and CS edge detection
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sck_pipe  <= '1;
            cs_pipe   <= '1;
            mosi_pipe <= '1;
            sck_hist  <= 1'b1;
            cs_hist   <= 1'b1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], SCK};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], CS};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
            sck_hist  <= sck_sync;
            cs_hist   <= cs_sync;
        end
    end

    // Edge decode and the word formed by the bit arriving now
    always_comb begin
        sck_sync  = sck_pipe[SYNC_STAGES-1];
        cs_sync   = cs_pipe[SYNC_STAGES-1];
        mosi_sync = mosi_pipe[SYNC_STAGES-1];
        sck_rise  = sck_sync & ~sck_hist;
        sck_fall  = ~sck_sync & sck_hist;
        cs_rise   = cs_sync & ~cs_hist;
        cs_fall   = ~cs_sync & cs_hist;
        rx_word   = {rx_shift, mosi_sync};
    end

    // Transfer FSM; CS edges take priority over SCK edges in the same cycle
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state          <= ST_IDLE;
            MISO           <= MISO_IDLE;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            tx_req         <= 1'b0;
            busy           <= 1'b0;
            idx            <= IDX_MSB;
            rx_shift       <= '0;
            tx_shift       <= '0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            abort          <= 1'b0;
            abort_bits     <= '0;
`endif
        end else begin
            data_out_valid <= 1'b0;
            tx_req         <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            abort          <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state    <= ST_ACTIVE;
                        busy     <= 1'b1;
                        tx_shift <= data_in;
                        MISO     <= data_in[DATA_WIDTH-1];
                        idx      <= IDX_MSB;
                        rx_shift <= '0;
                        tx_req   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        idx   <= IDX_MSB;
                        MISO  <= MISO_IDLE;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
                        if (idx != IDX_MSB) begin
                            abort      <= 1'b1;
                            abort_bits <= 4'(IDX_MSB - idx);
                        end
`endif
                    end else if (sck_rise) begin
                        rx_shift <= rx_word[DATA_WIDTH-2:0];
                        if (idx == '0) begin
                            data_out       <= rx_word;
                            data_out_valid <= 1'b1;
                            tx_shift       <= data_in;
                            tx_req         <= 1'b1;
                            idx            <= IDX_MSB;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end else if (sck_fall) begin
                        MISO <= tx_shift[idx];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and randomized SPI bursts against spi_slave.
// A bench-side master model drives SCK/CS/MOSI and collects MISO bytes; the
// expected MISO byte k of a frame is the data_in value presented at tx_req k.
module tb_spi_slave;

    logic       clk_in;
    logic       reset_in;
    logic       SCK;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] data_in;
    logic       tx_req;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       busy;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    logic       abort;
    logic [3:0] abort_bits;
    int         abort_cnt;
    logic [3:0] abort_seen_bits;
`endif

    int         checks;
    int         errors;
    int         tx_req_cnt;
    int         idle_viol;
    logic [7:0] send_q[$];
    logic [7:0] supply_q[$];
    logic [7:0] loaded_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    spi_slave #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2),
        .MISO_IDLE  (1'b1)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .SCK           (SCK),
        .CS            (CS),
        .MOSI          (MOSI),
        .MISO          (MISO),
        .data_in       (data_in),
        .tx_req        (tx_req),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        .abort         (abort),
        .abort_bits    (abort_bits),
`endif
        .busy          (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fabric side: record what the DUT loaded, then present the next byte
    initial begin
        tx_req_cnt = 0;
        idle_viol  = 0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        abort_cnt       = 0;
        abort_seen_bits = '0;
`endif
        forever begin
            @(negedge clk_in);
            if (tx_req === 1'b1) begin
                tx_req_cnt++;
                loaded_q.push_back(data_in);
                if (supply_q.size() > 0) data_in = supply_q.pop_front();
            end
            if (data_out_valid === 1'b1) rx_q.push_back(data_out);
            if (busy === 1'b0 && MISO !== 1'b1) idle_viol++;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            if (abort === 1'b1) begin
                abort_cnt++;
                abort_seen_bits = abort_bits;
            end
`endif
        end
    end

    // One master bit: SCK falls with new MOSI, MISO sampled just before SCK rises
    task automatic spi_bit(input logic mo, input int unsigned half, output logic mi);
        SCK  = 1'b0;
        MOSI = mo;
        repeat (half) @(negedge clk_in);
        mi  = MISO;
        SCK = 1'b1;
        repeat (half) @(negedge clk_in);
    endtask

    // One CS frame: all bytes of send_q, then extra_bits random bits, then CS high
    task automatic spi_frame(input int unsigned extra_bits, input int unsigned half);
        logic [7:0] acc;
        logic       b;
        miso_q.delete();
        loaded_q.delete();
        rx_q.delete();
        tx_req_cnt = 0;
        acc = '0;
        CS  = 1'b0;
        repeat (half) @(negedge clk_in);
        foreach (send_q[i]) begin
            for (int j = 7; j >= 0; j--) begin
                spi_bit(send_q[i][j], half, b);
                acc[j] = b;
            end
            miso_q.push_back(acc);
        end
        for (int unsigned k = 0; k < extra_bits; k++) spi_bit(1'($urandom), half, b);
        CS = 1'b1;
        repeat (10) @(negedge clk_in);
    endtask

    // Compare a completed full-byte frame against the master's view
    task automatic check_frame(input string tag);
        check({tag, "_rx_count"}, rx_q.size(), send_q.size());
        check({tag, "_txreq_count"}, tx_req_cnt, send_q.size() + 1);
        foreach (send_q[i]) begin
            if (i < rx_q.size()) check({tag, "_rx_byte"}, rx_q[i], send_q[i]);
            if (i < loaded_q.size()) check({tag, "_miso_byte"}, miso_q[i], loaded_q[i]);
        end
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_miso_idle"}, MISO, 1'b1);
    endtask

    initial begin
        logic b;
        logic [7:0] dout_before;
        int         txc_before;
        int         rxc_before;
        int unsigned half;
        checks   = 0;
        errors   = 0;
        reset_in = 1'b1;
        SCK      = 1'b1;
        CS       = 1'b1;
        MOSI     = 1'b1;
        data_in  = 8'h3C;
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;

        // Reset state
        check("rst_miso", MISO, 1'b1);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        check("rst_abort", abort, 1'b0);
        check("rst_abort_bits", abort_bits, 4'd0);
`endif

        // Single byte exchange
        send_q = '{8'hA5};
        spi_frame(0, 6);
        check_frame("single");
        check("single_miso_const", miso_q[0], 8'h3C);
        check("single_data_out", data_out, 8'hA5);

        // Two-byte burst with data_in switched on the first tx_req
        data_in = 8'h81;
        supply_q.push_back(8'h7E);
        send_q = '{8'h12, 8'hF0};
        spi_frame(0, 6);
        check_frame("burst2");
        check("burst2_miso0", miso_q[0], 8'h81);
        check("burst2_miso1", miso_q[1], 8'h7E);

        // Abort after 5 bits: nothing delivered, data_out held
        send_q.delete();
        spi_frame(5, 6);
        check("abort_no_valid", rx_q.size(), 0);
        check("abort_data_out", data_out, 8'hF0);
        check("abort_miso", MISO, 1'b1);
        check("abort_busy", busy, 1'b0);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        check("abort_pulses", abort_cnt, 1);
        check("abort_bits_seen", abort_seen_bits, 4'd5);
        check("abort_bits_held", abort_bits, 4'd5);
`endif
        send_q = '{8'h55};
        spi_frame(0, 6);
        check_frame("after_abort");
        check("after_abort_data_out", data_out, 8'h55);

        // Reset after 3 bits of a transfer
        CS = 1'b0;
        repeat (6) @(negedge clk_in);
        for (int i = 0; i < 3; i++) spi_bit(1'($urandom), 6, b);
        reset_in = 1'b1;
        CS       = 1'b1;
        SCK      = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        check("midrst_miso", MISO, 1'b1);
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_valid", data_out_valid, 1'b0);
        check("midrst_tx_req", tx_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        repeat (8) @(negedge clk_in);
        check("midrst_busy_settled", busy, 1'b0);
        send_q = '{8'hC3};
        spi_frame(0, 6);
        check_frame("post_rst");
        check("post_rst_data_out", data_out, 8'hC3);

        // SCK/MOSI noise while CS is high
        txc_before  = tx_req_cnt;
        rxc_before  = rx_q.size();
        dout_before = data_out;
        for (int i = 0; i < 16; i++) begin
            SCK  = ~SCK;
            MOSI = 1'($urandom);
            repeat (4) @(negedge clk_in);
        end
        repeat (6) @(negedge clk_in);
        check("noise_tx_req", tx_req_cnt, txc_before);
        check("noise_valid", rx_q.size(), rxc_before);
        check("noise_data_out", data_out, dout_before);
        check("noise_busy", busy, 1'b0);
        check("noise_miso_idle", idle_viol, 0);

        // Minimum clock ratio: 8-byte incrementing burst, random transmit bytes
        send_q.delete();
        for (int i = 0; i < 8; i++) begin
            send_q.push_back(8'(i));
            supply_q.push_back(8'($urandom));
        end
        data_in = 8'($urandom);
        spi_frame(0, 4);
        supply_q.delete();
        check_frame("minratio");

        // Randomized bursts at random master speeds
        for (int r = 0; r < 3; r++) begin
            send_q.delete();
            for (int i = 0; i < 3; i++) begin
                send_q.push_back(8'($urandom));
                supply_q.push_back(8'($urandom));
            end
            data_in = 8'($urandom);
            half    = $urandom_range(7, 4);
            spi_frame(0, half);
            supply_q.delete();
            check_frame("random");
        end

        check("final_miso_idle", idle_viol, 0);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        check("final_abort_pulses", abort_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the 8-bit, MSB-first link driven by our SPI master.
- All pin inputs are oversampled on clk_in: MOSI is captured on SCK rising edges and MISO is updated on SCK falling edges.
- Multi-byte bursts are supported (CS held low across bytes). Each received byte is handed to the fabric, and the next transmit byte is pulled from it.
- Sits between the FPGA pins and the control/register logic when the FPGA is the addressed device.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; shift order is MSB first.
- SYNC_STAGES, 2, synchronizer flops on SCK/CS/MOSI; minimum 2.
- MISO_IDLE, 1, MISO level while CS is high and after reset.

Ports:
- clk_in  input  1  system clock. Must be ≥ 4× the master's clock, because the master toggles SCK every master cycle.
- reset_in  input  1  synchronous reset, active-high.
- SCK  input  1  SPI clock from the master; idles high.
- CS  input  1  chip select, active low.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- data_in  input  DATA_WIDTH  next byte to transmit; sampled when tx_req pulses.
- tx_req  output  1  one-cycle pulse: data_in was just loaded, so present the following byte.
- data_out  output  DATA_WIDTH  last complete received byte; holds until the next byte completes.
- data_out_valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high while the synchronized CS is low.

Behaviour:
- Interface fixed: one clock, clk_in. Reset reset_in is synchronous and active-high.
- Reset values:
  - MISO=MISO_IDLE; data_out=0; data_out_valid=0; tx_req=0; busy=0.
  - Bit index=DATA_WIDTH-1; shift registers=0; synchronizer history=1 (idle high).
- Input path:
  - SCK, CS and MOSI each pass through SYNC_STAGES flops, then one extra history flop per signal for edge detection.
  - MOSI is delayed identically to SCK, so the sampled MOSI is aligned with the detected edge.
- Edge detection:
  - rise = sync 1 and history 0; fall = sync 0 and history 1.
  - Detection latency is SYNC_STAGES+1 clk_in cycles from the pin.
- States: IDLE (CS high) and ACTIVE (CS low). busy = ACTIVE.
- CS falling (IDLE→ACTIVE):
  - tx_shift←data_in; MISO←data_in[MSB]; idx←DATA_WIDTH-1.
  - rx_shift is cleared; tx_req pulses.
  - A coincident SCK fall in the same cycle is subsumed by this action.
- SCK rise in ACTIVE:
  - rx_shift←{rx_shift[W-2:0], MOSI_sync}.
  - If idx==0: data_out←the completed word and data_out_valid=1 on the next cycle; tx_shift←data_in and tx_req pulses in that same next cycle; idx←W-1.
  - Otherwise idx←idx-1.
- SCK fall in ACTIVE (not coincident with CS fall): MISO←tx_shift[idx].
  - This drives the next bit, or the MSB of the newly loaded byte after a wrap.
- CS rising (ACTIVE→IDLE), including mid-byte:
  - The partial byte is discarded: no data_out_valid, data_out unchanged.
  - idx←W-1; MISO←MISO_IDLE.
- IDLE:
  - SCK and MOSI activity is ignored; no pulses are generated.
- Simultaneous events (same cycle):
  - CS rise together with SCK rise: CS wins, and the bit is not captured.
  - CS fall together with SCK rise: impossible under master timing, so treat it as a CS fall only.
- reset_in mid-transfer:
  - All state returns to reset values in the next cycle.
  - The first transfer after reset requires a fresh CS falling edge, because the history flops reset high.
- Timing:
  - The MISO update after an SCK fall completes within SYNC_STAGES+2 clk_in cycles.
  - This must precede the master's next SCK rise, which sets the clock-ratio requirement above.
- No FIFO. If data_in is not updated between tx_req pulses, the same byte is resent.

Optional Feature:
- Macro: SPI_SLAVE_ABORT_FLAG_EN.
- Defined:
  - Adds output abort (1 bit), a one-cycle pulse when CS rises with 1..W-1 bits received in the current word.
  - Adds output abort_bits (4 bits), holding that received-bit count until the next abort.
  - Both reset to 0.
- Undefined:
  - Neither port exists; a mid-byte CS rise silently discards the partial byte.

Test Plan:
- Single byte exchange: data_in=0x3C, master sends 0xA5 with one CS pulse.
  - Expect tx_req at the CS fall.
  - Expect MISO bit sequence 0,0,1,1,1,1,0,0.
  - Expect data_out=0xA5 with one data_out_valid pulse and busy low after CS rises.
- Two-byte burst: CS held low, master sends 0x12 then 0xF0; data_in is changed from 0x81 to 0x7E on the first tx_req.
  - Expect data_out_valid pulses with 0x12, then 0xF0.
  - Expect MISO to shift out 0x81, then 0x7E.
  - Expect 2 tx_req pulses total, plus one more after byte 2.
- Abort: CS rises after 5 SCK rises.
  - Expect no data_out_valid, data_out unchanged, and MISO=1.
  - Next full byte 0x55 → data_out=0x55.
  - With SPI_SLAVE_ABORT_FLAG_EN defined: expect an abort pulse and abort_bits=5.
- Reset mid-transfer: reset_in asserted for 1 cycle after 3 bits.
  - Expect all outputs at reset values.
  - After a new CS cycle sending 0xC3, expect data_out=0xC3.
- CS-high noise: SCK toggles 16 times with MOSI random while CS is high.
  - Expect no data_out_valid, no tx_req, and MISO=1 throughout.
- Minimum clock ratio: clk_in exactly 4× the master clock, 8-byte burst of incrementing values 0x00..0x07.
  - Expect all 8 bytes received correctly, with no MISO bit errors seen at the master.
